// File: rtl/unpool_pkg.sv
//==============================================================================
// Module   : unpool_pkg
// Purpose  : Shared types and constants for the 2x unpool job controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

package unpool_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4,
    S_HALT   = 3'd5
  } unpool_ctrl_state_e;

  localparam logic [1:0] STS_OK       = 2'd0;
  localparam logic [1:0] STS_BADCFG   = 2'd1;
  localparam logic [1:0] STS_TIMEOUT  = 2'd2;
  localparam logic [1:0] STS_MISMATCH = 2'd3;

  localparam int unsigned UNPOOL_MAX_LINE_BITS = 16384;
  localparam int unsigned UNPOOL_WD_W          = 21;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  elem_bits;
    logic [7:0]  kind;
    logic [7:0]  scale;
    logic [15:0] h;
    logic [15:0] w;
    logic [15:0] c;
  } unpool_desc_t;

  function automatic logic elem_bits_ok(input logic [7:0] bits);
    return (bits == 8'd2) || (bits == 8'd4) || (bits == 8'd8) ||
           (bits == 8'd16) || (bits == 8'd32);
  endfunction

endpackage

`default_nettype wire

// File: rtl/unpool_desc_fifo.sv
//==============================================================================
// Module   : unpool_desc_fifo
// Purpose  : Synchronous descriptor FIFO with registered full/empty flags.
// Revision : 1.0
//==============================================================================
`default_nettype none

module unpool_desc_fifo
  import unpool_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  unpool_desc_t wdata,
  input  logic         pop,
  output unpool_desc_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned c_addr_w = $clog2(QDEPTH);
  localparam logic [c_addr_w:0] c_depth = (c_addr_w + 1)'(QDEPTH);

  unpool_desc_t            r_mem [QDEPTH];
  logic [c_addr_w-1:0]     r_wptr;
  logic [c_addr_w-1:0]     r_rptr;
  logic [c_addr_w:0]       r_count;
  logic [c_addr_w:0]       w_count_next;
  logic                    r_full;
  logic                    r_empty;
  logic                    w_do_push;
  logic                    w_do_pop;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_pop  = pop && !r_empty;
  assign w_do_push = push && (!r_full || w_do_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_depth);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/unpool2d_ctrl.sv
//==============================================================================
// Module   : unpool2d_ctrl
// Purpose  : Job scheduler for the 2x nearest-neighbour unpool unit.
// Revision : 1.0
//==============================================================================
`default_nettype none

module unpool2d_ctrl
  import unpool_pkg::*;
#(
  parameter int unsigned BUS_W   = 128,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [7:0]  desc_id,
  input  logic [7:0]  desc_elem_bits,
  input  logic [7:0]  desc_kind,
  input  logic [7:0]  desc_scale,
  input  logic [15:0] desc_h_in,
  input  logic [15:0] desc_w_in,
  input  logic [15:0] desc_c,
  output logic [7:0]  cfg_elem_bits,
  output logic [7:0]  cfg_unpool_kind,
  output logic [7:0]  cfg_scale,
  output logic [15:0] cfg_h_in,
  output logic [15:0] cfg_w_in,
  output logic [15:0] cfg_c,
  output logic        unit_start,
  input  logic        unit_busy,
  input  logic        unit_done,
  input  logic        mon_out_valid,
  input  logic        mon_out_ready,
  output logic        sts_valid,
  input  logic        sts_ready,
  output logic [7:0]  sts_id,
  output logic [1:0]  sts_code,
  output logic [31:0] sts_beats,
  output logic        halted,
  input  logic        clr
);

  localparam logic [UNPOOL_WD_W-1:0] c_wd_limit = UNPOOL_WD_W'(TIMEOUT - 1);

  unpool_ctrl_state_e     r_state, w_state_next;
  unpool_desc_t           w_wdata, w_head, r_job, w_job_next;
  logic                   w_push, w_pop, w_full, w_empty;
  logic [31:0]            r_expected, w_expected_next;
  logic [31:0]            r_count, w_count_next, w_count_inc;
  logic [UNPOOL_WD_W-1:0] r_wd, w_wd_next, w_wd_step;
  logic                   r_start, w_start_next;
  logic                   r_sts_valid, w_sts_valid_next;
  logic [7:0]             r_sts_id, w_sts_id_next;
  logic [1:0]             r_sts_code, w_sts_code_next;
  logic [31:0]            r_sts_beats, w_sts_beats_next;
  logic                   r_halted, w_halted_next;
  logic                   w_beat, w_legal;
  logic [31:0]            w_line_bits, w_line_beats, w_expected;

  assign w_wdata = '{id: desc_id, elem_bits: desc_elem_bits, kind: desc_kind,
                     scale: desc_scale, h: desc_h_in, w: desc_w_in, c: desc_c};
  assign w_push  = desc_valid && !w_full;

  unpool_desc_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Job legality and beat budget, evaluated on the registered job during CHECK.
  assign w_line_bits  = {16'd0, r_job.w} * {16'd0, r_job.c} * {24'd0, r_job.elem_bits};
  assign w_legal      = elem_bits_ok(r_job.elem_bits) && (r_job.scale == 8'd2) &&
                        (r_job.kind == 8'd0) && (r_job.h != 16'd0) &&
                        (r_job.w != 16'd0) && (r_job.c != 16'd0) &&
                        (w_line_bits <= 32'(UNPOOL_MAX_LINE_BITS));
  assign w_line_beats = ((w_line_bits << 1) + 32'(BUS_W - 1)) / 32'(BUS_W);
  assign w_expected   = ({16'd0, r_job.h} << 1) * w_line_beats;

  assign w_beat      = mon_out_valid && mon_out_ready;
  assign w_count_inc = r_count + {31'd0, w_beat};
  assign w_wd_step   = w_beat ? '0 : r_wd + 1'b1;

  always_comb begin
    w_state_next     = r_state;
    w_job_next       = r_job;
    w_expected_next  = r_expected;
    w_count_next     = r_count;
    w_wd_next        = r_wd;
    w_start_next     = 1'b0;
    w_sts_valid_next = r_sts_valid;
    w_sts_id_next    = r_sts_id;
    w_sts_code_next  = r_sts_code;
    w_sts_beats_next = r_sts_beats;
    w_halted_next    = r_halted;
    w_pop            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !unit_busy) begin
          w_pop        = 1'b1;
          w_job_next   = w_head;
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_legal) begin
          w_expected_next = w_expected;
          w_start_next    = 1'b1;
          w_state_next    = S_ISSUE;
        end else begin
          w_sts_valid_next = 1'b1;
          w_sts_id_next    = r_job.id;
          w_sts_code_next  = STS_BADCFG;
          w_sts_beats_next = '0;
          w_state_next     = S_REPORT;
        end
      end
      S_ISSUE: begin
        w_count_next = '0;
        w_wd_next    = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_count_next = w_count_inc;
        w_wd_next    = w_wd_step;
        // Completion outranks a watchdog expiry landing in the same cycle.
        if (unit_done) begin
          w_sts_valid_next = 1'b1;
          w_sts_id_next    = r_job.id;
          w_sts_code_next  = (w_count_inc == r_expected) ? STS_OK : STS_MISMATCH;
          w_sts_beats_next = w_count_inc;
          w_state_next     = S_REPORT;
        end else if (w_wd_step == c_wd_limit) begin
          w_sts_valid_next = 1'b1;
          w_sts_id_next    = r_job.id;
          w_sts_code_next  = STS_TIMEOUT;
          w_sts_beats_next = w_count_inc;
          w_state_next     = S_REPORT;
        end
      end
      S_REPORT: begin
        if (sts_ready) begin
          w_sts_valid_next = 1'b0;
          if (r_sts_code == STS_TIMEOUT) begin
            w_halted_next = 1'b1;
            w_state_next  = S_HALT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_HALT: begin
        if (clr) begin
          w_halted_next = 1'b0;
          w_wd_next     = '0;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_job       <= '0;
      r_expected  <= '0;
      r_count     <= '0;
      r_wd        <= '0;
      r_start     <= 1'b0;
      r_sts_valid <= 1'b0;
      r_sts_id    <= '0;
      r_sts_code  <= '0;
      r_sts_beats <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_job       <= w_job_next;
      r_expected  <= w_expected_next;
      r_count     <= w_count_next;
      r_wd        <= w_wd_next;
      r_start     <= w_start_next;
      r_sts_valid <= w_sts_valid_next;
      r_sts_id    <= w_sts_id_next;
      r_sts_code  <= w_sts_code_next;
      r_sts_beats <= w_sts_beats_next;
      r_halted    <= w_halted_next;
    end
  end

  assign desc_ready      = !w_full;
  assign cfg_elem_bits   = r_job.elem_bits;
  assign cfg_unpool_kind = r_job.kind;
  assign cfg_scale       = r_job.scale;
  assign cfg_h_in        = r_job.h;
  assign cfg_w_in        = r_job.w;
  assign cfg_c           = r_job.c;
  assign unit_start      = r_start;
  assign sts_valid       = r_sts_valid;
  assign sts_id          = r_sts_id;
  assign sts_code        = r_sts_code;
  assign sts_beats       = r_sts_beats;
  assign halted          = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_unpool2d_ctrl.sv
//==============================================================================
// Module   : tb_unpool2d_ctrl
// Purpose  : Scoreboard bench for unpool2d_ctrl with a behavioural unit model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_unpool2d_ctrl;

  localparam int BUS_W   = 128;
  localparam int QDEPTH  = 4;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        desc_valid, desc_ready;
  logic [7:0]  desc_id, desc_elem_bits, desc_kind, desc_scale;
  logic [15:0] desc_h_in, desc_w_in, desc_c;
  logic [7:0]  cfg_elem_bits, cfg_unpool_kind, cfg_scale;
  logic [15:0] cfg_h_in, cfg_w_in, cfg_c;
  logic        unit_start, unit_busy, unit_done;
  logic        mon_out_valid, mon_out_ready;
  logic        sts_valid, sts_ready;
  logic [7:0]  sts_id;
  logic [1:0]  sts_code;
  logic [31:0] sts_beats;
  logic        halted, clr;

  unpool2d_ctrl #(
    .BUS_W   (BUS_W),
    .QDEPTH  (QDEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_id         (desc_id),
    .desc_elem_bits  (desc_elem_bits),
    .desc_kind       (desc_kind),
    .desc_scale      (desc_scale),
    .desc_h_in       (desc_h_in),
    .desc_w_in       (desc_w_in),
    .desc_c          (desc_c),
    .cfg_elem_bits   (cfg_elem_bits),
    .cfg_unpool_kind (cfg_unpool_kind),
    .cfg_scale       (cfg_scale),
    .cfg_h_in        (cfg_h_in),
    .cfg_w_in        (cfg_w_in),
    .cfg_c           (cfg_c),
    .unit_start      (unit_start),
    .unit_busy       (unit_busy),
    .unit_done       (unit_done),
    .mon_out_valid   (mon_out_valid),
    .mon_out_ready   (mon_out_ready),
    .sts_valid       (sts_valid),
    .sts_ready       (sts_ready),
    .sts_id          (sts_id),
    .sts_code        (sts_code),
    .sts_beats       (sts_beats),
    .halted          (halted),
    .clr             (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [7:0]  id, elem, kind, scale;
    bit [15:0] h, w, c;
  } desc_s;

  typedef struct {
    bit [7:0]  id;
    bit [1:0]  code;
    bit [31:0] beats;
  } sts_s;

  typedef struct {
    int        target;
    bit        hang;
    bit [71:0] cfg;
  } plan_s;

  sts_s  exp_q[$];
  plan_s plan_q[$];
  int    tests = 0;
  int    fails = 0;
  int    rst_count = 0;
  bit    bp_hold = 1'b0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic logic [71:0] cfg_now();
    return {cfg_elem_bits, cfg_unpool_kind, cfg_scale, cfg_h_in, cfg_w_in, cfg_c};
  endfunction

  // Reference model: line size, legality and beat budget straight from the job rules.
  function automatic longint ref_line_bits(input desc_s d);
    longint unsigned p;
    p = longint'(d.w) * longint'(d.c) * longint'(d.elem);
    return longint'(p & 64'h0000_0000_FFFF_FFFF);
  endfunction

  function automatic bit ref_legal(input desc_s d);
    return (d.elem inside {8'd2, 8'd4, 8'd8, 8'd16, 8'd32}) && d.scale == 8'd2 &&
           d.kind == 8'd0 && d.h != 0 && d.w != 0 && d.c != 0 &&
           ref_line_bits(d) <= 16384;
  endfunction

  function automatic int ref_beats(input desc_s d);
    longint lb;
    lb = ref_line_bits(d);
    return int'(2 * longint'(d.h) * ((2 * lb + BUS_W - 1) / BUS_W));
  endfunction

  function automatic desc_s mk(input int id, input int elem, input int kind,
                               input int scale, input int h, input int w, input int c);
    desc_s d;
    d.id = 8'(id); d.elem = 8'(elem); d.kind = 8'(kind); d.scale = 8'(scale);
    d.h = 16'(h); d.w = 16'(w); d.c = 16'(c);
    return d;
  endfunction

  function automatic desc_s rand_desc(input int id);
    desc_s d;
    int elems[5];
    elems = '{2, 4, 8, 16, 32};
    d = mk(id, elems[$urandom % 5], 0, 2, 1 + int'($urandom % 3),
           1 + int'($urandom % 6), 1 + int'($urandom % 6));
    if ($urandom % 5 == 0) begin
      case ($urandom % 5)
        0: d.elem  = 8'($urandom % 40);
        1: d.scale = 8'($urandom % 4);
        2: d.kind  = 8'(1 + $urandom % 3);
        3: d.c     = 16'd0;
        default: begin d.w = 16'd600; d.c = 16'd1; d.elem = 8'd32; end
      endcase
    end
    return d;
  endfunction

  // mode: 0 runs to completion, 1 stops one beat short, 2 hangs after 3 beats.
  task automatic send_desc(input desc_s d, input int mode);
    int    guard;
    bit    done;
    sts_s  s;
    plan_s p;
    int    e;
    guard = 0;
    done  = 1'b0;
    desc_valid = 1'b1;
    desc_id = d.id; desc_elem_bits = d.elem; desc_kind = d.kind; desc_scale = d.scale;
    desc_h_in = d.h; desc_w_in = d.w; desc_c = d.c;
    while (!done && guard < 2000) begin
      guard++;
      @(negedge clk);
      if (desc_ready) begin
        done = 1'b1;
        s.id = d.id;
        if (!ref_legal(d)) begin
          s.code = 2'd1; s.beats = 32'd0;
        end else begin
          e = ref_beats(d);
          p.cfg = {d.elem, d.kind, d.scale, d.h, d.w, d.c};
          p.hang = (mode == 2);
          p.target = (mode == 0) ? e : (mode == 1) ? e - 1 : 3;
          plan_q.push_back(p);
          s.code  = (mode == 0) ? 2'd0 : (mode == 1) ? 2'd3 : 2'd2;
          s.beats = 32'(p.target);
        end
        exp_q.push_back(s);
      end
      @(posedge clk); #1;
    end
    desc_valid = 1'b0;
    check("desc_accept_in_time", done, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || unit_busy) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check({"drain_", name}, guard < 5000, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_ready"}, desc_ready, 1'b1);
    check({tag, "_unit_start"}, unit_start, 1'b0);
    check({tag, "_sts_valid"}, sts_valid, 1'b0);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_cfg"}, cfg_now(), 72'd0);
    check({tag, "_sts_fields"}, {sts_id, sts_code, sts_beats}, 42'd0);
  endtask

  // Status monitor: stability while stalled, then compare against the scoreboard.
  initial begin : monitor
    sts_s got, prev, want;
    bit   have_prev, expect_halt;
    have_prev = 1'b0;
    expect_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
        expect_halt = 1'b0;
      end else begin
        if (expect_halt) begin
          check("halted_after_timeout", halted, 1'b1);
          expect_halt = 1'b0;
        end
        if (sts_valid) begin
          got.id = sts_id; got.code = sts_code; got.beats = sts_beats;
          if (have_prev)
            check("sts_held_stable", {got.id, got.code, got.beats},
                  {prev.id, prev.code, prev.beats});
          if (sts_ready) begin
            have_prev = 1'b0;
            if (exp_q.size() == 0) begin
              check("sts_expected_pending", exp_q.size(), 1);
            end else begin
              want = exp_q.pop_front();
              check("sts_id", got.id, want.id);
              check("sts_code", got.code, want.code);
              check("sts_beats", got.beats, want.beats);
              if (want.code == 2'd2) expect_halt = 1'b1;
            end
          end else begin
            prev = got;
            have_prev = 1'b1;
          end
        end else begin
          have_prev = 1'b0;
        end
      end
    end
  end

  // Behavioural unpool unit: emits the planned number of output beats then done.
  initial begin : model_unit
    plan_s p;
    int    rc, emitted, guard;
    bit    finished, moved, beat;
    unit_busy = 1'b0; unit_done = 1'b0;
    mon_out_valid = 1'b0; mon_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && unit_start) begin
        if (plan_q.size() == 0) begin
          check("start_has_legal_job", plan_q.size(), 1);
        end else begin
          p = plan_q.pop_front();
          check("cfg_at_start", cfg_now(), p.cfg);
          rc = rst_count; emitted = 0; guard = 0;
          finished = 1'b0; moved = 1'b0;
          @(posedge clk); #1;
          unit_busy = 1'b1;
          while (!finished && rst_n && guard < 3000) begin
            guard++;
            mon_out_valid = 1'b0; mon_out_ready = 1'b0; unit_done = 1'b0;
            if (emitted < p.target) begin
              mon_out_valid = ($urandom % 8) != 0;
              mon_out_ready = ($urandom % 8) != 0;
              beat = mon_out_valid && mon_out_ready;
              if (beat) emitted++;
              if (beat && emitted == p.target && !p.hang && ($urandom % 2) == 1) begin
                unit_done = 1'b1;
                finished = 1'b1;
              end
            end else if (p.hang) begin
              finished = halted;
            end else begin
              unit_done = 1'b1;
              finished = 1'b1;
            end
            if (cfg_now() != p.cfg) moved = 1'b1;
            @(posedge clk); #1;
          end
          mon_out_valid = 1'b0; mon_out_ready = 1'b0;
          unit_done = 1'b0; unit_busy = 1'b0;
          if (rc == rst_count) begin
            check("job_finished_in_time", guard < 3000, 1'b1);
            check("cfg_stable_during_job", moved, 1'b0);
          end
        end
      end
    end
  end

  initial begin : sts_ready_drv
    sts_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      sts_ready = bp_hold ? 1'b0 : (($urandom % 4) != 0);
    end
  end

  initial begin : clr_drv
    int hc;
    hc = 0;
    clr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && halted) begin
        check("no_start_while_halted", unit_start, 1'b0);
        hc++;
        if (hc >= 8) begin
          @(posedge clk); #1 clr = 1'b1;
          @(posedge clk); #1 clr = 1'b0;
          hc = 0;
        end
      end
    end
  end

  initial begin : global_bound
    #600000;
    fails++;
    $display("FAIL global_time_limit: got expired, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : stimulus
    desc_s d;
    int    guard;
    rst_n = 1'b0;
    desc_valid = 1'b0;
    desc_id = '0; desc_elem_bits = '0; desc_kind = '0; desc_scale = '0;
    desc_h_in = '0; desc_w_in = '0; desc_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal legal job: 8 beats.
    send_desc(mk(1, 8, 0, 2, 2, 4, 4), 0);
    wait_drain("legal");

    // Rejected configurations.
    send_desc(mk(2, 6, 0, 2, 2, 4, 4), 0);
    send_desc(mk(3, 8, 0, 3, 2, 4, 4), 0);
    send_desc(mk(4, 8, 0, 2, 2, 4, 0), 0);
    send_desc(mk(5, 32, 0, 2, 2, 1024, 1), 0);
    wait_drain("illegal");

    // Unit stops one beat short.
    send_desc(mk(6, 8, 0, 2, 2, 4, 4), 1);
    wait_drain("short");

    // Hang with a second job queued behind it.
    send_desc(mk(7, 8, 0, 2, 2, 4, 4), 2);
    send_desc(mk(8, 16, 0, 2, 1, 3, 2), 0);
    wait_drain("hang");

    // Back-pressure on status while the FIFO fills.
    bp_hold = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_desc(mk(100 + i, 8, 0, 2, 1, 2 + i, 4), 0);
      end
      begin
        bit seen;
        int g;
        seen = 1'b0;
        g = 0;
        while (!seen && g < 300) begin
          @(negedge clk);
          g++;
          if (!desc_ready) seen = 1'b1;
        end
        repeat (10) @(negedge clk);
        check("desc_ready_drops_when_full", seen, 1'b1);
        @(posedge clk); #1 bp_hold = 1'b0;
      end
    join
    wait_drain("backpressure");

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      d = rand_desc(20 + i);
      send_desc(d, ($urandom % 5 == 0) ? 1 : 0);
      repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
    wait_drain("random");

    // Reset in the middle of a long job.
    send_desc(mk(200, 32, 0, 2, 3, 6, 6), 0);
    guard = 0;
    while (!unit_busy && guard < 200) begin @(posedge clk); #1; guard++; end
    check("long_job_started", unit_busy, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst_count++;
    rst_n = 1'b0;
    exp_q.delete();
    plan_q.delete();
    #1;
    check_reset_outputs("mid_job_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    guard = 0;
    while (unit_busy && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    send_desc(mk(201, 4, 0, 2, 2, 8, 2), 0);
    wait_drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
